// File: rtl/mux_pipe_pkg.sv
// Shared types and helpers for the registered N-way pipeline selector.
package mux_pipe_pkg;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_TWO   = 2'd2
   } state_t;

   // Select width for an n-way mux; never narrower than one bit.
   function automatic int sel_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/mux_n.sv
// Combinational NUM_IN:1 word selector; out-of-range select yields zero and raises err.
module mux_n #(
   parameter int WIDTH  = 32,
   parameter int NUM_IN = 4,
   parameter int SEL_W  = 2
) (
   input  logic [NUM_IN*WIDTH-1:0] d,
   input  logic [SEL_W-1:0]        sel,
   output logic [WIDTH-1:0]        y,
   output logic                    err
);

   always_comb begin
      y   = '0;
      err = 1'b1;
      for (int unsigned k = 0; k < NUM_IN; k++) begin
         if (sel == SEL_W'(k)) begin
            y   = d[k*WIDTH +: WIDTH];
            err = 1'b0;
         end
      end
   end

endmodule

// File: rtl/mux_pipe.sv
// Registered N-way selector stage with valid/ready handshake and a two-entry skid buffer.
module mux_pipe import mux_pipe_pkg::*; #(
   parameter int WIDTH  = 32,
   parameter int NUM_IN = 4,
   parameter int SEL_W  = sel_width(NUM_IN)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    flush,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [NUM_IN*WIDTH-1:0] d,
   input  logic [SEL_W-1:0]        sel,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [WIDTH-1:0]        out,
   output logic                    sel_err
);

   state_t           state_q;
   logic [WIDTH-1:0] main_q;
   logic [WIDTH-1:0] skid_q;
   logic [WIDTH-1:0] word;
   logic             word_err;
   logic             ready_q;
   logic             err_q;
   logic             acc;
   logic             drn;

   mux_n #(
      .WIDTH (WIDTH),
      .NUM_IN(NUM_IN),
      .SEL_W (SEL_W)
   ) u_mux (
      .d  (d),
      .sel(sel),
      .y  (word),
      .err(word_err)
   );

   assign acc = in_valid & ready_q;
   assign drn = (state_q != ST_EMPTY) & out_ready;

   // ready_q tracks the next state so in_ready stays a plain register output.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_EMPTY;
         main_q  <= '0;
         skid_q  <= '0;
         ready_q <= 1'b1;
         err_q   <= 1'b0;
      end else if (flush) begin
         state_q <= ST_EMPTY;
         ready_q <= 1'b1;
         err_q   <= 1'b0;
      end else begin
         err_q <= acc & word_err;
         case (state_q)
            ST_EMPTY: begin
               if (acc) begin
                  main_q  <= word;
                  state_q <= ST_ONE;
               end
            end
            ST_ONE: begin
               if (acc && !drn) begin
                  skid_q  <= word;
                  state_q <= ST_TWO;
                  ready_q <= 1'b0;
               end else if (acc) begin
                  main_q <= word;
               end else if (drn) begin
                  state_q <= ST_EMPTY;
               end
            end
            ST_TWO: begin
               if (drn) begin
                  main_q  <= skid_q;
                  state_q <= ST_ONE;
                  ready_q <= 1'b1;
               end
            end
            default: begin
               state_q <= ST_EMPTY;
               ready_q <= 1'b1;
            end
         endcase
      end
   end

   assign out_valid = (state_q != ST_EMPTY);
   assign in_ready  = ready_q;
   assign out       = main_q;
   assign sel_err   = err_q;

endmodule

// File: tb/tb_mux_pipe.sv
// Bench for mux_pipe: four parameterisations checked against a queue-based occupancy model.
module tb_mux_pipe;

   localparam int NI = 4;
   localparam int WW [NI] = '{32, 32, 8, 64};
   localparam int NN [NI] = '{4, 3, 2, 16};
   localparam int SW [NI] = '{2, 2, 1, 4};

   logic clk = 1'b0;
   logic rst = 1'b1;

   logic          iv   [NI];
   logic          ordy [NI];
   logic          fl   [NI];
   logic [1023:0] dd   [NI];
   logic [3:0]    ss   [NI];
   logic          ov   [NI];
   logic          ir   [NI];
   logic          se   [NI];
   logic [63:0]   oo   [NI];

   logic [31:0] o0;
   logic [31:0] o1;
   logic [7:0]  o2;
   logic [63:0] o3;

   always_comb begin
      oo[0] = 64'(o0);
      oo[1] = 64'(o1);
      oo[2] = 64'(o2);
      oo[3] = o3;
   end

   always #5 clk = ~clk;

   mux_pipe #(.WIDTH(32), .NUM_IN(4)) dut0 (
      .clk(clk), .rst(rst), .flush(fl[0]), .in_valid(iv[0]), .in_ready(ir[0]),
      .d(dd[0][127:0]), .sel(ss[0][1:0]), .out_valid(ov[0]), .out_ready(ordy[0]),
      .out(o0), .sel_err(se[0]));

   mux_pipe #(.WIDTH(32), .NUM_IN(3)) dut1 (
      .clk(clk), .rst(rst), .flush(fl[1]), .in_valid(iv[1]), .in_ready(ir[1]),
      .d(dd[1][95:0]), .sel(ss[1][1:0]), .out_valid(ov[1]), .out_ready(ordy[1]),
      .out(o1), .sel_err(se[1]));

   mux_pipe #(.WIDTH(8), .NUM_IN(2)) dut2 (
      .clk(clk), .rst(rst), .flush(fl[2]), .in_valid(iv[2]), .in_ready(ir[2]),
      .d(dd[2][15:0]), .sel(ss[2][0:0]), .out_valid(ov[2]), .out_ready(ordy[2]),
      .out(o2), .sel_err(se[2]));

   mux_pipe #(.WIDTH(64), .NUM_IN(16)) dut3 (
      .clk(clk), .rst(rst), .flush(fl[3]), .in_valid(iv[3]), .in_ready(ir[3]),
      .d(dd[3]), .sel(ss[3]), .out_valid(ov[3]), .out_ready(ordy[3]),
      .out(o3), .sel_err(se[3]));

   // Reference state: FIFO contents, last word held on out, pending sel_err.
   logic [63:0] q      [NI][$];
   logic [63:0] last   [NI];
   bit          experr [NI];
   bit          mv     [NI];
   bit          m_acc;
   bit          m_drn;
   int          total = 0;
   int          bad   = 0;

   function automatic logic [63:0] exp_word(int i, logic [1023:0] d, logic [3:0] s);
      logic [63:0]   m;
      logic [1023:0] sh;
      if (int'(s) >= NN[i]) return '0;
      m  = (WW[i] == 64) ? '1 : ((64'd1 << WW[i]) - 64'd1);
      sh = d >> (int'(s) * WW[i]);
      return sh[63:0] & m;
   endfunction

   task automatic chk(string nm, int i, logic [63:0] act, logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s inst%0d t=%0t got=%h want=%h", nm, i, $time, act, exp);
      end
   endtask

   // Monitor: compare what the DUT presents, then advance the model with the inputs the next edge samples.
   always @(negedge clk) begin
      for (int i = 0; i < NI; i++) begin
         if (mv[i]) begin
            chk("out_valid", i, 64'(ov[i]), 64'(q[i].size() != 0));
            chk("in_ready",  i, 64'(ir[i]), 64'(q[i].size() < 2));
            chk("sel_err",   i, 64'(se[i]), 64'(experr[i]));
            chk("out",       i, oo[i], (q[i].size() != 0) ? q[i][0] : last[i]);
         end
         if (rst) begin
            q[i].delete();
            last[i]   = '0;
            experr[i] = 1'b0;
            mv[i]     = 1'b1;
         end else if (fl[i]) begin
            if (q[i].size() != 0) last[i] = q[i][0];
            q[i].delete();
            experr[i] = 1'b0;
         end else begin
            m_acc = iv[i] && (q[i].size() < 2);
            m_drn = (q[i].size() != 0) && ordy[i];
            if (m_drn) void'(q[i].pop_front());
            if (m_acc) q[i].push_back(exp_word(i, dd[i], ss[i]));
            experr[i] = m_acc && (int'(ss[i]) >= NN[i]);
            if (q[i].size() != 0) last[i] = q[i][0];
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      for (int i = 0; i < NI; i++) begin
         iv[i] = 1'b0; ordy[i] = 1'b0; fl[i] = 1'b0; dd[i] = '0; ss[i] = '0;
      end
      // reset with in_valid asserted
      rst = 1'b1; iv[0] = 1'b1; iv[1] = 1'b1;
      step(); step();
      rst = 1'b0; iv[0] = 1'b0; iv[1] = 1'b0;
      step();

      // streaming, no backpressure
      dd[0][127:0] = {32'h44, 32'h33, 32'h22, 32'h11};
      ordy[0] = 1'b1;
      for (int k = 0; k < 4; k++) begin
         iv[0] = 1'b1; ss[0] = 4'(k);
         step();
      end
      iv[0] = 1'b0;
      step(); step();

      // backpressure into TWO, then drain in order
      ordy[0] = 1'b0;
      dd[0][31:0] = 32'hA; dd[0][63:32] = 32'hB;
      iv[0] = 1'b1; ss[0] = 4'd0; step();
      ss[0] = 4'd1; step();
      iv[0] = 1'b0; step(); step();
      ordy[0] = 1'b1; step(); step(); step();
      ordy[0] = 1'b0;

      // out-of-range select on the 3-way instance
      dd[1][95:64] = 32'hFF; ordy[1] = 1'b1;
      iv[1] = 1'b1; ss[1] = 4'd3; step();
      ss[1] = 4'd2; step();
      iv[1] = 1'b0; step(); step();

      // flush in TWO with a coincident offer
      ordy[0] = 1'b0; dd[0][95:64] = 32'hC; dd[0][127:96] = 32'hD;
      iv[0] = 1'b1; ss[0] = 4'd2; step();
      ss[0] = 4'd3; step();
      fl[0] = 1'b1; ss[0] = 4'd1; step();
      fl[0] = 1'b0; iv[0] = 1'b0; step();
      ordy[0] = 1'b1; step(); step();
      ordy[0] = 1'b0;

      // flush coinciding with an accepted bad select: sel_err must stay low
      ordy[1] = 1'b0;
      iv[1] = 1'b1; ss[1] = 4'd0; step();
      ss[1] = 4'd3; fl[1] = 1'b1; step();
      fl[1] = 1'b0; iv[1] = 1'b0; step(); step();

      // random valid/ready/flush on every instance
      for (int c = 0; c < 3000; c++) begin
         for (int i = 0; i < NI; i++) begin
            iv[i]   = 1'($urandom_range(0, 1));
            ordy[i] = ($urandom_range(0, 3) != 0);
            fl[i]   = ($urandom_range(0, 40) == 0);
            ss[i]   = 4'($urandom_range(0, (1 << SW[i]) - 1));
            for (int w = 0; w < 32; w++) dd[i][w*32 +: 32] = $urandom;
         end
         step();
      end

      for (int i = 0; i < NI; i++) begin
         iv[i] = 1'b0; fl[i] = 1'b0; ordy[i] = 1'b1;
      end
      step(); step(); step(); step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mux_pipe.md
# mux_pipe

Parametrised N-way, W-bit registered selector with a valid/ready handshake and a two-entry skid buffer. It generalises the combinational 2:1 word mux of the MIPS datapath into a pipeline-stage mux: one input word is chosen per accepted transfer, and the result is held until the consumer takes it. Used at stage boundaries (PC-source, writeback-source, forwarding select) where stall and flush must be honoured without losing or duplicating data.

## Interface
- WIDTH, 32: data word width in bits (≥1).
- NUM_IN, 4: number of data inputs (2..16).
- SEL_W, $clog2(NUM_IN): select width (derived; not overridden).
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  drop all buffered entries this cycle.
- in_valid  in  1  producer offers d/sel.
- in_ready  out  1  block can accept (registered).
- d  in  NUM_IN*WIDTH  packed inputs; input k is d[k*WIDTH +: WIDTH].
- sel  in  SEL_W  input index, sampled with in_valid.
- out_valid  out  1  out holds a valid word.
- out_ready  in  1  consumer takes out this cycle.
- out  out  WIDTH  selected word (registered).
- sel_err  out  1  one-cycle pulse: an accepted sel was ≥ NUM_IN.

One clock (clk). Reset is synchronous and active-high (rst).

## Operation
- Accept: in_valid & in_ready at a rising edge. Captured word = d[sel]. If sel ≥ NUM_IN, the word is all-zeros and sel_err pulses on the next cycle.
- Storage: main register (drives out) and skid register. State EMPTY (0 entries), ONE (main valid), TWO (main and skid valid).
- out_valid = (state != EMPTY). in_ready = (state != TWO), registered from next-state.
- Drain: out_valid & out_ready.
- Transitions, with accept a and drain r:
  - EMPTY: a → ONE, load main.
  - ONE: a & !r → TWO, load skid; !a & r → EMPTY; a & r → ONE, load main; else hold.
  - TWO: r → ONE, main ← skid. No accept is possible because in_ready = 0.
- flush (synchronous): state → EMPTY and in_ready → 1 on the next edge. flush overrides accept and drain: a coincident accept is discarded and sel_err is suppressed. out retains its stale value but out_valid = 0.
- rst has priority over flush and all other inputs.
- Ordering is strict FIFO. No word is duplicated or dropped except by flush or rst.

## Timing
- Reset values: out_valid = 0, in_ready = 1, out = 0, sel_err = 0, state EMPTY, skid = 0.
- Latency: a word accepted at edge n appears on out with out_valid = 1 after edge n.
- Throughput: 1 word/cycle when out_ready is held high.
- in_ready is registered, so the producer sees it drop one cycle late. The skid entry absorbs the one in-flight word.
- out_ready low with state TWO: in_ready = 0 until the first drain edge, then 1 the cycle after.
- sel_err is high for exactly the cycle after the offending accept.
- No combinational path from in_valid, out_ready or d to any output.

## Structure
- Package mux_pipe_pkg holds:
  - state encoding constants ST_EMPTY = 2'd0, ST_ONE = 2'd1, ST_TWO = 2'd2;
  - a function that computes SEL_W from NUM_IN.
- Sub-module mux_n: purely combinational NUM_IN:1, WIDTH-bit selector with out-of-range → 0 and a range-error flag. It is reused by the datapath as a drop-in generalisation of the 2:1 word mux.
- The handshake/state logic stays in mux_pipe.

## Test plan
- Reset: assert rst for 2 cycles with in_valid = 1 → out_valid = 0, in_ready = 1, out = 0x00000000, sel_err = 0 throughout.
- Streaming: d = {0x44,0x33,0x22,0x11}, sel = 0,1,2,3 on consecutive cycles, out_ready = 1 → out = 0x11,0x22,0x33,0x44 on cycles 1–4, no bubbles.
- Backpressure: out_ready = 0, offer 0xA and then 0xB →
  - state TWO, with in_ready = 0 from the cycle after the second accept;
  - raise out_ready → out = 0xA, then 0xB, in order;
  - in_ready returns to 1 one cycle after the first drain.
- Bad select: NUM_IN = 3, sel = 3, d2 = 0xFF → out = 0x0 with out_valid = 1, sel_err high for one cycle only.
- Flush in TWO with a coincident in_valid → next cycle out_valid = 0, in_ready = 1, the coincident word never appears, sel_err = 0.
- Parameter sweep: WIDTH = 8, NUM_IN = 2 and WIDTH = 64, NUM_IN = 16 with random valid/ready → scoreboard shows in-order, lossless transfer.
